// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared memory bus: round-robin with a master-1 burst lock,
// one single-byte transfer per ACCESS/RESP pair, and ROM write protection for master 0.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] ROM_LIMIT = 16'h0100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   cur_we;
  logic   cur_blk;
  logic   last_served;
  logic   lock_own;

  logic              arb_edge;
  logic              any_req;
  logic              grant_m1;
  logic              g_we;
  logic              g_blk;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              lock_nxt;

  // A held lock beats round robin; otherwise a tie goes to whoever was not served last.
  function automatic logic pick_m1(input logic r0, input logic r1,
                                   input logic lock, input logic last);
    if (lock && r1)
      return 1'b1;
    if (r0 && r1)
      return ~last;
    return r1;
  endfunction

  function automatic logic rom_blocked(input logic we, input logic [ADDR_W-1:0] addr);
    return we && (addr < ROM_LIMIT);
  endfunction

  always_comb begin
    arb_edge = (state != S_ACCESS);
    any_req  = m0_req | m1_req;
    grant_m1 = pick_m1(m0_req, m1_req, lock_own, last_served);
    g_we     = grant_m1 ? m1_we    : m0_we;
    g_addr   = grant_m1 ? m1_addr  : m0_addr;
    g_wdata  = grant_m1 ? m1_wdata : m0_wdata;
    g_blk    = ~grant_m1 & rom_blocked(m0_we, m0_addr);

    lock_nxt = lock_own;
    if (arb_edge && any_req && grant_m1 && m1_lock)
      lock_nxt = 1'b1;
    else if (!m1_lock)
      lock_nxt = 1'b0;
    else if (arb_edge && !any_req)
      lock_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      cur_we      <= 1'b0;
      cur_blk     <= 1'b0;
      last_served <= 1'b1;
      lock_own    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      m0_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      busy        <= 1'b0;
    end else begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      lock_own <= lock_nxt;
      case (state)
        S_ACCESS: begin
          // Access ends: capture read data and raise the owner's completion pulse.
          state <= S_RESP;
          if (!cur_we) begin
            if (owner)
              m1_rdata <= mem_rdata;
            else
              m0_rdata <= mem_rdata;
          end
          m0_ack <= ~owner;
          m1_ack <= owner;
          m0_err <= ~owner & cur_blk;
        end
        default: begin
          // IDLE or RESP: arbitrate and launch the next access, or fall back to idle.
          if (any_req) begin
            state       <= S_ACCESS;
            busy        <= 1'b1;
            owner       <= grant_m1;
            last_served <= grant_m1;
            cur_we      <= g_we;
            cur_blk     <= g_blk;
            mem_addr    <= g_addr;
            mem_wdata   <= g_wdata;
            mem_rd      <= ~g_we;
            mem_wr      <= g_we & ~g_blk;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of single transfers plus hand sequences for
// round robin, the master-1 lock burst and reset during an access.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [7:0]  m0_wdata = '0;
  logic        m0_ack, m0_err;
  logic [7:0]  m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [7:0]  m1_wdata = '0;
  logic        m1_ack;
  logic [7:0]  m1_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd, mem_wr, busy;
  logic [7:0]  mem_rdata;

  logic [7:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          m;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          err;
    logic [7:0]  rdata;
  } vec_t;

  typedef struct {
    bit         m;
    bit         err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LIMIT(16'h0100)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_lock(m1_lock),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) begin
      check("strobe_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      check("ack_exclusive", 32'(m0_ack & m1_ack), 32'd0);
      if (m0_ack || m1_ack) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b, expected none", m0_ack, m1_ack);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_master", 32'(m1_ack), 32'(e.m));
          check("ack_err", 32'(m0_err), 32'(e.err));
          check("ack_rdata", 32'(e.m ? m1_rdata : m0_rdata), 32'(e.rdata));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc, rd_seen, wr_seen;
    bit got, addr_ok;
    exp_t e;
    @(negedge clk);
    if (v.m) begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    e.m = v.m; e.err = v.err; e.rdata = v.rdata;
    sb.push_back(e);
    cyc = 0; rd_seen = 0; wr_seen = 0; got = 1'b0; addr_ok = 1'b1;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      rd_seen += int'(mem_rd);
      wr_seen += int'(mem_wr);
      if ((mem_rd || mem_wr) && mem_addr != v.addr) addr_ok = 1'b0;
      got = v.m ? m1_ack : m0_ack;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("vec_latency", 32'(cyc), 32'd2);
    check("vec_rd_strobe", 32'(rd_seen), 32'(!v.we));
    check("vec_wr_strobe", 32'(wr_seen), 32'(v.we && !v.err));
    check("vec_strobe_addr", 32'(addr_ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, cyc, n1;
    bit   m0_done;
    int   ack_cyc[4];
    bit   own[4];
    exp_t e;

    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    mem[16'h0005] = 8'hAA;

    // m, we, addr, wdata, err, rdata (rdata = held value for writes)
    vecs[0]  = '{1'b0, 1'b0, 16'h0005, 8'h00, 1'b0, 8'hAA};
    vecs[1]  = '{1'b0, 1'b1, 16'h0200, 8'h5A, 1'b0, 8'hAA};
    vecs[2]  = '{1'b0, 1'b0, 16'h0200, 8'h00, 1'b0, 8'h5A};
    vecs[3]  = '{1'b0, 1'b1, 16'h0010, 8'h77, 1'b1, 8'h5A};
    vecs[4]  = '{1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, 8'h2C};
    vecs[5]  = '{1'b1, 1'b1, 16'h0010, 8'h99, 1'b0, 8'h3E};
    vecs[6]  = '{1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 8'h99};
    vecs[7]  = '{1'b0, 1'b1, 16'h00FF, 8'h11, 1'b1, 8'h2C};
    vecs[8]  = '{1'b0, 1'b1, 16'h0100, 8'h22, 1'b0, 8'h2C};
    vecs[9]  = '{1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 8'h22};
    vecs[10] = '{1'b0, 1'b0, 16'h00FF, 8'h00, 1'b0, 8'hC3};
    vecs[11] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h3C};
    vecs[12] = '{1'b0, 1'b1, 16'hFFFF, 8'h44, 1'b0, 8'hC3};
    vecs[13] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h44};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack, m0_err}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    reset = 1'b1;

    // Both masters requesting from reset: M0 first, then strict alternation.
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0300;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0301;
    for (int i = 0; i < 4; i++) begin
      e.m = i[0]; e.err = 1'b0; e.rdata = i[0] ? 8'h3E : 8'h3F;
      sb.push_back(e);
      ack_cyc[i] = 0; own[i] = 1'b0;
    end
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m0_ack || m1_ack) begin
        ack_cyc[k] = cyc; own[k] = m1_ack; k++;
        if (k == 4) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("rr_ack_count", 32'(k), 32'd4);
    check("rr_first_ack", 32'(ack_cyc[0]), 32'd2);
    for (int i = 1; i < 4; i++) begin
      check("rr_ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);
      check("rr_alternate", 32'(own[i] ^ own[i-1]), 32'd1);
    end
    repeat (2) @(negedge clk);
    check("rr_idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);
    repeat (2) @(negedge clk);
    check("rom_0010_kept", 32'(mem[16'h0010]), 32'h99);
    check("rom_00ff_kept", 32'(mem[16'h00FF]), 32'hC3);

    // Locked master-1 burst holds off a waiting master 0.
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0000; m1_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.m = 1'b1; e.err = 1'b0; e.rdata = 8'h3C + 8'(i);
      sb.push_back(e);
    end
    e.m = 1'b0; e.err = 1'b0; e.rdata = 8'h38;
    sb.push_back(e);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0400;
    n1 = 0; m0_done = 1'b0; cyc = 0;
    while (!m0_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m1_ack) begin
        n1++;
        if (n1 < 4) m1_addr = 16'(n1);
        else begin m1_req = 1'b0; m1_lock = 1'b0; end
      end
      if (m0_ack) begin
        m0_done = 1'b1;
        m0_req = 1'b0;
        check("lock_m1_acks_before_m0", 32'(n1), 32'd4);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    check("lock_m0_served", 32'(m0_done), 32'd1);
    repeat (2) @(negedge clk);

    // Reset asserted mid-write: everything drops at once and the write never lands.
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0500; m1_wdata = 8'h66;
    @(negedge clk);
    check("arst_wr_active", 32'(mem_wr), 32'd1);
    #2;
    reset = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0;
    #1;
    check("arst_mem_wr", 32'(mem_wr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_busy_after", 32'(busy), 32'd0);
    check("arst_mem_kept", 32'(mem[16'h0500]), 32'h39);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
